// File: rtl/counter_if.sv
// Control/status bundle for the up/down counter: count controls in, count and flags out.
interface counter_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] out;
  logic             tc;
  logic             wrap;

  modport master (
    output en, up_dn, load, load_val,
    input  out, tc, wrap
  );

  modport slave (
    input  en, up_dn, load, load_val,
    output out, tc, wrap
  );
endinterface

// File: rtl/counter.sv
// Up/down binary counter with synchronous enable, parallel load, terminal count and wrap pulse.
// Optional build macro COUNTER_SAT_EN: saturate at all-ones/zero instead of wrapping.
module counter #(
  parameter int          WIDTH = 8,
  parameter int unsigned STEP  = 1
) (
  input logic      clk,
  input logic      rst,
  counter_if.slave bus
);

  localparam logic [WIDTH:0] C_STEP = (WIDTH+1)'(STEP);

  logic [WIDTH-1:0] r_out;
  logic             r_wrap;

  logic [WIDTH:0]   w_sum_up;
  logic [WIDTH:0]   w_sum_dn;
  logic             w_carry;
  logic             w_borrow;
  logic [WIDTH-1:0] w_next;
  logic             w_wrap_next;

  // One extra bit on both paths exposes carry/borrow out of the WIDTH-bit count.
  assign w_sum_up = {1'b0, r_out} + C_STEP;
  assign w_sum_dn = {1'b0, r_out} - C_STEP;
  assign w_carry  = w_sum_up[WIDTH];
  assign w_borrow = w_sum_dn[WIDTH];

  always_comb begin
    w_next      = r_out;
    w_wrap_next = 1'b0;
    if (bus.load) begin
      w_next = bus.load_val;
    end else if (bus.en) begin
      if (bus.up_dn) begin
`ifdef COUNTER_SAT_EN
        w_next      = w_carry ? '1 : w_sum_up[WIDTH-1:0];
`else
        w_next      = w_sum_up[WIDTH-1:0];
`endif
        w_wrap_next = w_carry;
      end else begin
`ifdef COUNTER_SAT_EN
        w_next      = w_borrow ? '0 : w_sum_dn[WIDTH-1:0];
`else
        w_next      = w_sum_dn[WIDTH-1:0];
`endif
        w_wrap_next = w_borrow;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out  <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_out  <= w_next;
      r_wrap <= w_wrap_next;
    end
  end

  assign bus.out  = r_out;
  assign bus.wrap = r_wrap;
  assign bus.tc   = bus.up_dn ? (&r_out) : ~(|r_out);

endmodule

// File: tb/tb_counter.sv
// Scoreboard bench for counter: stimulus queues hand-computed results, a monitor checks each cycle.
module tb_counter;

  typedef struct packed {
    logic [7:0] out;
    logic       tc;
    logic       wrap;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t q[$];

  counter_if #(.WIDTH(8)) bus ();

  counter #(.WIDTH(8), .STEP(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input exp_t act, input exp_t req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got out=%02h tc=%0b wrap=%0b, want out=%02h tc=%0b wrap=%0b",
               name, act.out, act.tc, act.wrap, req.out, req.tc, req.wrap);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] o, input logic t, input logic w);
    exp_t e;
    e.out  = o;
    e.tc   = t;
    e.wrap = w;
    return e;
  endfunction

  function automatic exp_t dut_now();
    return mk(bus.out, bus.tc, bus.wrap);
  endfunction

  // Drive one cycle's inputs at the falling edge and queue the result expected after the next rise.
  task automatic cyc(input logic en, input logic up, input logic ld, input logic [7:0] lv,
                     input logic [7:0] eo, input logic etc, input logic ew);
    @(negedge clk);
    bus.en       = en;
    bus.up_dn    = up;
    bus.load     = ld;
    bus.load_val = lv;
    q.push_back(mk(eo, etc, ew));
  endtask

  initial begin : monitor
    int n;
    n = 0;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        n++;
        chk($sformatf("cycle%0d", n), dut_now(), q.pop_front());
      end
    end
  end

  initial begin : stim
    int t;
    checks = 0;
    errors = 0;
    rst          = 1'b0;
    bus.en       = 1'b1;
    bus.up_dn    = 1'b1;
    bus.load     = 1'b0;
    bus.load_val = 8'h00;

    #3  chk("reset_up",   dut_now(), mk(8'h00, 1'b0, 1'b0));
    bus.up_dn = 1'b0;
    #1  chk("reset_tc_dn", dut_now(), mk(8'h00, 1'b1, 1'b0));
    bus.up_dn = 1'b1;
    #4  rst = 1'b1;                                            // t=8
    #8  chk("first_count", dut_now(), mk(8'h01, 1'b0, 1'b0)); // t=16
    #1  rst = 1'b0;                                            // t=17
    #1  chk("async_rst",  dut_now(), mk(8'h00, 1'b0, 1'b0));  // t=18
    #9  chk("rst_held",   dut_now(), mk(8'h00, 1'b0, 1'b0));  // t=27
    #1  rst = 1'b1;                                            // t=28

    // Resume counting
    cyc(1, 1, 0, 8'h00, 8'h01, 0, 0);
    cyc(1, 1, 0, 8'h00, 8'h02, 0, 0);
    cyc(1, 1, 0, 8'h00, 8'h03, 0, 0);
    // Load FE then count up across the top
    cyc(1, 1, 1, 8'hFE, 8'hFE, 0, 0);
    cyc(1, 1, 0, 8'h00, 8'hFF, 1, 0);
`ifdef COUNTER_SAT_EN
    cyc(1, 1, 0, 8'h00, 8'hFF, 1, 1);
    cyc(0, 1, 0, 8'h00, 8'hFF, 1, 0);
`else
    cyc(1, 1, 0, 8'h00, 8'h00, 0, 1);
    cyc(0, 1, 0, 8'h00, 8'h00, 0, 0);
`endif
    // Load 02 then count down across zero
    cyc(0, 1, 1, 8'h02, 8'h02, 0, 0);
    cyc(1, 0, 0, 8'h00, 8'h01, 0, 0);
    cyc(1, 0, 0, 8'h00, 8'h00, 1, 0);
`ifdef COUNTER_SAT_EN
    cyc(1, 0, 0, 8'h00, 8'h00, 1, 1);
    cyc(0, 0, 0, 8'h00, 8'h00, 1, 0);
`else
    cyc(1, 0, 0, 8'h00, 8'hFF, 0, 1);
    cyc(0, 0, 0, 8'h00, 8'hFF, 0, 0);
`endif
    // Load wins over enable, then hold five cycles
    cyc(1, 1, 1, 8'h3C, 8'h3C, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 8'h00, 8'h3C, 0, 0);
    // Simultaneous load and enable, then direction change
    cyc(1, 1, 1, 8'h80, 8'h80, 0, 0);
    cyc(1, 1, 0, 8'h00, 8'h81, 0, 0);
    cyc(1, 0, 0, 8'h00, 8'h80, 0, 0);
    // tc follows up_dn on a held all-ones value
    cyc(0, 1, 1, 8'hFF, 8'hFF, 1, 0);
    cyc(0, 0, 0, 8'h00, 8'hFF, 0, 0);
    // Load right after a wrap clears the pulse
`ifdef COUNTER_SAT_EN
    cyc(1, 1, 0, 8'h00, 8'hFF, 1, 1);
`else
    cyc(1, 1, 0, 8'h00, 8'h00, 0, 1);
`endif
    cyc(1, 1, 1, 8'h10, 8'h10, 0, 0);

    t = 0;
    while (q.size() > 0 && t < 50) begin
      @(posedge clk);
      t++;
    end
    #5;
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
